mcu51_timer: RTL
================

# mcu51_timer

Timer/counter peripheral (8051 Timer 0 and Timer 1) on the MCU51 core's internal SFR bus, next to the port block that drives P0–P3. It divides CLK into machine-cycle ticks and implements TCON[7:4], TMOD, TL0/TH0 and TL1/TH1 with modes 0–2, counter inputs and gating. It raises level interrupt requests to the interrupt controller and accepts vector acknowledges back.

## Interface
Parameters:
- CLK_PER_MC, 12: CLK cycles per machine cycle (≥2).
- ADDR_TCON, 8'h88 / ADDR_TMOD, 8'h89 / ADDR_TL0, 8'h8A / ADDR_TL1, 8'h8B / ADDR_TH0, 8'h8C / ADDR_TH1, 8'h8D: SFR addresses.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sfr_addr  in  8  SFR address (write and read).
- sfr_we  in  1  write strobe, one CLK.
- sfr_wdata  in  8  write data.
- sfr_rdata  out  8  combinational read of the addressed register; 0 when unmapped.
- sfr_hit  out  1  1 when sfr_addr matches one of the six addresses.
- t0_in, t1_in  in  1  counter pins, already synchronous to CLK.
- int0_n, int1_n  in  1  gate pins, already synchronous to CLK.
- tf0_ack, tf1_ack  in  1  one-CLK pulse from interrupt controller on vectoring; clears TFx.
- irq_t0, irq_t1  out  1  equal to TF0 / TF1.

## Operation
- Prescaler: counts 0..CLK_PER_MC-1 then wraps, free-running. tick=1 in the CLK where the prescaler equals CLK_PER_MC-1.
- TMOD: [7:4] Timer 1 and [3:0] Timer 0, each as GATE, C/T, M1, M0. TCON: bit7 TF1, bit6 TR1, bit5 TF0, bit4 TR0. Bits 3:0 belong to the interrupt block: they read 0 and writes to them are ignored.
- run_x = TRx & (~GATEx | intx_n).
- Count event, on a tick only:
  - C/T=0: every tick while run_x.
  - C/T=1: while run_x, when the tx_in sample held from the previous tick is 1 and the current sample is 0. The sample register updates on every tick, running or not.
- Modes, on a count event:
  - Mode 0: 13-bit {TH, TL[4:0]} increments. TL[7:5] is unchanged. At 0x1FFF it wraps to 0 and sets TF.
  - Mode 1: 16-bit {TH, TL}. At 0xFFFF it wraps to 0 and sets TF.
  - Mode 2: TL increments. At 0xFF, TL<=TH and TF is set. TH is unchanged.
  - Mode 3: the timer holds; no counting, no TF.
- TF set by overflow stays set until tf_ack or a TCON write with that bit 0.

## Timing
- Reset: prescaler, TMOD, TCON, TL0/TH0/TL1/TH1 and edge samples all 0. irq_t0=irq_t1=0; sfr_rdata follows its address (0 for 0x88 after reset).
- Register writes take effect on the CLK edge of sfr_we. Reads are combinational and zero-latency.
- Counter update and TF set land on the same edge as the tick. irq_x is high the CLK after that edge.
- Collisions, same CLK:
  - SFR write to TL/TH and a count event on the same timer: the written byte wins, and the other byte is not incremented that tick.
  - TCON write and overflow: TF = written bit OR overflow (set wins).
  - tf_ack and overflow: TF stays 1.
- TR set by a write becomes effective at the next tick. The count stops at the first tick after TR clears.
- Reset asserted mid-count: everything returns to reset values on that edge, and the prescaler restarts at 0.

## Test plan
- Reset: assert reset 2 CLKs → every address reads 0x00, sfr_hit=1 for 0x88–0x8D and 0 for 0x80, irq_t0=irq_t1=0.
- Mode 1 overflow: TMOD=0x01, TH0=0xFF, TL0=0xFE, TCON=0x10 → after 2 ticks TH0/TL0=0x00/0x00, TCON=0x30, irq_t0=1. Pulse tf0_ack → TCON=0x10, irq_t0=0.
- Mode 2 reload: TMOD=0x20, TH1=0xF0, TL1=0xFE, TCON=0x40 → after 2 ticks TL1=0xF0, TF1=1. After 16 more ticks TL1=0xF0 again.
- Counter: TMOD=0x50, TCON=0x40. Give t1_in 3 falling edges, each level held ≥2 ticks → TL1=0x03, TH1=0x00. A glitch shorter than one tick → no count.
- Gate: TMOD=0x09, TCON=0x10, int0_n=0 for 5 ticks → TL0=0x00. Then int0_n=1 for 5 ticks → TL0=0x05.
- Collisions:
  - Write TL0=0x55 on the tick CLK while counting → TL0=0x55.
  - Assert tf0_ack on the overflow CLK → TF0=1.
  - Mode 0, TH0=0xFF, TL0=0xFF → after 1 tick TH0=0x00, TL0=0xE0, TF0=1.

Source files
------------

// File: rtl/mcu51_timer.sv
// -----------------------------------------------------------------------------
// mcu51_timer
// Timer 0 / Timer 1 peripheral of the MCU51 core, sitting on the internal SFR
// bus. A free-running prescaler turns CLK into one tick per machine cycle.
// Each timer counts either ticks (timer) or falling edges seen on its pin at
// tick rate (counter). Modes 0, 1, 2 and 3 follow the classic 8051 TMOD
// encoding. TCON[7:4] holds the run and overflow flags. TCON[3:0] belongs to
// the interrupt block, so those bits read as zero here.
//
// Ports
//   CLK            system clock; all state changes on the rising edge
//   reset          synchronous, active-high reset
//   sfr_addr       SFR address used for both writes and reads
//   sfr_we         one-CLK write strobe
//   sfr_wdata      write data
//   sfr_rdata      combinational read of the addressed register (0 if unmapped)
//   sfr_hit        1 when sfr_addr selects one of the six timer registers
//   t0_in, t1_in   counter pins, already synchronous to CLK
//   int0_n, int1_n gate pins, already synchronous to CLK
//   tf0_ack/tf1_ack one-CLK vector acknowledge; clears the matching TF
//   irq_t0/irq_t1  level interrupt requests, equal to TF0 / TF1
// -----------------------------------------------------------------------------
module mcu51_timer #(
  parameter int         CLK_PER_MC = 12,
  parameter logic [7:0] ADDR_TCON  = 8'h88,
  parameter logic [7:0] ADDR_TMOD  = 8'h89,
  parameter logic [7:0] ADDR_TL0   = 8'h8A,
  parameter logic [7:0] ADDR_TL1   = 8'h8B,
  parameter logic [7:0] ADDR_TH0   = 8'h8C,
  parameter logic [7:0] ADDR_TH1   = 8'h8D
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] sfr_addr,
  input  logic       sfr_we,
  input  logic [7:0] sfr_wdata,
  output logic [7:0] sfr_rdata,
  output logic       sfr_hit,
  input  logic       t0_in,
  input  logic       t1_in,
  input  logic       int0_n,
  input  logic       int1_n,
  input  logic       tf0_ack,
  input  logic       tf1_ack,
  output logic       irq_t0,
  output logic       irq_t1
);

  localparam int            PW         = $clog2(CLK_PER_MC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MC - 1);

  // One count step of a timer. Returns {overflow, th_next, tl_next}.
  // Mode 0 is a 13-bit counter made of TH and TL[4:0]; TL[7:5] rides along
  // untouched. Mode 2 reloads TL from TH on overflow. Mode 3 holds.
  function automatic logic [16:0] timer_step(input logic [1:0] mode,
                                             input logic [7:0] tl,
                                             input logic [7:0] th);
    logic [12:0] v13;
    logic [15:0] v16;
    logic [16:0] res;
    v13 = 13'd0;
    v16 = 16'd0;
    res = {1'b0, th, tl};
    case (mode)
      2'd0: begin
        v13 = {th, tl[4:0]} + 13'd1;
        res = {(v13 == 13'd0), v13[12:5], tl[7:5], v13[4:0]};
      end
      2'd1: begin
        v16 = {th, tl} + 16'd1;
        res = {(v16 == 16'd0), v16};
      end
      2'd2: begin
        if (tl == 8'hFF) begin
          res = {1'b1, th, th};
        end else begin
          res = {1'b0, th, tl + 8'd1};
        end
      end
      default: begin
        res = {1'b0, th, tl};
      end
    endcase
    return res;
  endfunction

  // Prescaler and tick
  logic [PW-1:0] presc_r;
  logic          tick_s;

  // Architectural registers; index 0 is Timer 0, index 1 is Timer 1
  logic [7:0]      tmod_r;
  logic [1:0]      tr_r;
  logic [1:0]      tf_r;
  logic [1:0]      samp_r;
  logic [1:0][7:0] tl_r;
  logic [1:0][7:0] th_r;

  // Next-state and decode signals
  logic [1:0][7:0]  tl_nxt_s;
  logic [1:0][7:0]  th_nxt_s;
  logic [1:0]       tr_nxt_s;
  logic [1:0]       tf_nxt_s;
  logic [1:0][16:0] step_s;
  logic [1:0]       run_s;
  logic [1:0]       cnt_ev_s;
  logic [1:0]       bump_s;
  logic [1:0]       ovf_s;
  logic [1:0]       wr_tl_s;
  logic [1:0]       wr_th_s;
  logic [1:0]       pin_s;
  logic [1:0]       gate_pin_s;
  logic [1:0]       ack_s;
  logic             wr_tcon_s;
  logic             wr_tmod_s;

  assign tick_s     = (presc_r == PRESC_LAST);
  assign pin_s      = {t1_in, t0_in};
  assign gate_pin_s = {int1_n, int0_n};
  assign ack_s      = {tf1_ack, tf0_ack};

  assign wr_tcon_s  = sfr_we & (sfr_addr == ADDR_TCON);
  assign wr_tmod_s  = sfr_we & (sfr_addr == ADDR_TMOD);
  assign wr_tl_s    = {sfr_we & (sfr_addr == ADDR_TL1), sfr_we & (sfr_addr == ADDR_TL0)};
  assign wr_th_s    = {sfr_we & (sfr_addr == ADDR_TH1), sfr_we & (sfr_addr == ADDR_TH0)};

  assign sfr_hit = (sfr_addr == ADDR_TCON) | (sfr_addr == ADDR_TMOD) |
                   (sfr_addr == ADDR_TL0)  | (sfr_addr == ADDR_TL1)  |
                   (sfr_addr == ADDR_TH0)  | (sfr_addr == ADDR_TH1);

  // The interrupt requests are the TF flip-flops themselves
  assign irq_t0 = tf_r[0];
  assign irq_t1 = tf_r[1];

  // Count events and next-state for both timers
  always_comb begin
    run_s    = 2'b00;
    cnt_ev_s = 2'b00;
    bump_s   = 2'b00;
    ovf_s    = 2'b00;
    step_s   = '{default: 17'd0};
    tl_nxt_s = tl_r;
    th_nxt_s = th_r;
    tr_nxt_s = tr_r;
    tf_nxt_s = tf_r;
    for (int i = 0; i < 2; i++) begin
      // TMOD nibble per timer: [3] GATE, [2] C/T, [1:0] mode
      run_s[i] = tr_r[i] & (~tmod_r[4*i+3] | gate_pin_s[i]);
      if (tmod_r[4*i+2]) begin
        // Counter: falling edge between the previous tick's sample and now
        cnt_ev_s[i] = tick_s & run_s[i] & samp_r[i] & ~pin_s[i];
      end else begin
        cnt_ev_s[i] = tick_s & run_s[i];
      end
      step_s[i] = timer_step(tmod_r[4*i +: 2], tl_r[i], th_r[i]);

      // A CPU write to either byte suppresses the whole count step, so the
      // untouched byte does not see a half-applied carry either.
      bump_s[i] = cnt_ev_s[i] & ~wr_tl_s[i] & ~wr_th_s[i];
      ovf_s[i]  = bump_s[i] & step_s[i][16];

      if (wr_tl_s[i]) begin
        tl_nxt_s[i] = sfr_wdata;
      end else if (bump_s[i]) begin
        tl_nxt_s[i] = step_s[i][7:0];
      end else begin
        tl_nxt_s[i] = tl_r[i];
      end

      if (wr_th_s[i]) begin
        th_nxt_s[i] = sfr_wdata;
      end else if (bump_s[i]) begin
        th_nxt_s[i] = step_s[i][15:8];
      end else begin
        th_nxt_s[i] = th_r[i];
      end

      // TR lives at TCON bit 4 (Timer 0) and bit 6 (Timer 1)
      if (wr_tcon_s) begin
        tr_nxt_s[i] = sfr_wdata[4+2*i];
      end else begin
        tr_nxt_s[i] = tr_r[i];
      end

      // Overflow beats both a software clear and an acknowledge, so an
      // event landing in the same CLK is never lost.
      if (ovf_s[i]) begin
        tf_nxt_s[i] = 1'b1;
      end else if (wr_tcon_s) begin
        tf_nxt_s[i] = sfr_wdata[5+2*i];
      end else if (ack_s[i]) begin
        tf_nxt_s[i] = 1'b0;
      end else begin
        tf_nxt_s[i] = tf_r[i];
      end
    end
  end

  // Combinational SFR read mux
  always_comb begin
    case (sfr_addr)
      ADDR_TCON: sfr_rdata = {tf_r[1], tr_r[1], tf_r[0], tr_r[0], 4'b0000};
      ADDR_TMOD: sfr_rdata = tmod_r;
      ADDR_TL0:  sfr_rdata = tl_r[0];
      ADDR_TL1:  sfr_rdata = tl_r[1];
      ADDR_TH0:  sfr_rdata = th_r[0];
      ADDR_TH1:  sfr_rdata = th_r[1];
      default:   sfr_rdata = 8'h00;
    endcase
  end

  // Prescaler, pin samples and all timer registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      presc_r <= {PW{1'b0}};
      tmod_r  <= 8'h00;
      tr_r    <= 2'b00;
      tf_r    <= 2'b00;
      samp_r  <= 2'b00;
      tl_r    <= '{default: 8'h00};
      th_r    <= '{default: 8'h00};
    end else begin
      if (tick_s) begin
        presc_r <= {PW{1'b0}};
        samp_r  <= pin_s;
      end else begin
        presc_r <= presc_r + PW'(1);
        samp_r  <= samp_r;
      end
      if (wr_tmod_s) begin
        tmod_r <= sfr_wdata;
      end else begin
        tmod_r <= tmod_r;
      end
      tr_r <= tr_nxt_s;
      tf_r <= tf_nxt_s;
      tl_r <= tl_nxt_s;
      th_r <= th_nxt_s;
    end
  end

endmodule
